// File: rtl/switch_reader.sv
// Bus-readable switch/button peripheral: synchronises and debounces raw pads,
// latches button presses into write-1-to-clear flags and raises a level interrupt.
module switch_reader #(
  parameter logic [31:0] BASE     = 32'h20,
  parameter int          SWITCHES = 8,
  parameter int          BUTTONS  = 4,
  parameter int          DEB_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                strobe,
  input  logic                rw,
  input  logic [31:0]         addr,
  input  logic [31:0]         d_in,
  output logic [31:0]         d_out,
  input  logic [SWITCHES-1:0] sw,
  input  logic [BUTTONS-1:0]  btn,
  output logic                pending
);

  localparam int N = SWITCHES + BUTTONS;

  logic [N-1:0]        pads;
  logic [N-1:0]        sync1_q, sync1_d;
  logic [N-1:0]        sync2_q, sync2_d;
  logic [N-1:0]        stable_q, stable_d;
  logic [N-1:0][1:0]   agr_q, agr_d;
  logic [DEB_BITS-1:0] presc_q, presc_d;
  logic                tick;
  logic [BUTTONS-1:0]  flag_q, flag_d;
  logic [BUTTONS-1:0]  press, clear;
  logic                pending_q, pending_d;
  logic [31:0]         d_out_q, d_out_d;
  logic [31:0]         reg0, reg1;
  logic                in_range;
  logic                unused_d_in;

  // Switches occupy the low part of the shared debounce vector, buttons the high part.
  assign pads        = {btn, sw};
  assign unused_d_in = ^d_in[31:BUTTONS];

  always_comb begin
    sync1_d = pads;
    sync2_d = sync1_q;
    presc_d = presc_q + 1'b1;
    tick    = &presc_q;
  end

  // A new level is accepted only on the third consecutive disagreeing tick.
  always_comb begin
    stable_d = stable_q;
    agr_d    = agr_q;
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (agr_q[i] == 2'd2) begin
            stable_d[i] = sync2_q[i];
            agr_d[i]    = 2'd0;
          end else begin
            agr_d[i] = agr_q[i] + 2'd1;
          end
        end else begin
          agr_d[i] = 2'd0;
        end
      end
    end
  end

  always_comb begin
    in_range  = (addr[31:1] == BASE[31:1]);
    press     = stable_d[SWITCHES +: BUTTONS] & ~stable_q[SWITCHES +: BUTTONS];
    clear     = '0;
    if (strobe && rw && in_range && addr[0]) begin
      clear = d_in[BUTTONS-1:0];
    end
    // A press landing in the same cycle as a clear must not be lost.
    flag_d    = (flag_q & ~clear) | press;
    pending_d = |flag_d;
  end

  always_comb begin
    reg0                    = '0;
    reg0[SWITCHES-1:0]      = stable_q[SWITCHES-1:0];
    reg0[16 +: BUTTONS]     = stable_q[SWITCHES +: BUTTONS];
    reg1                    = '0;
    reg1[BUTTONS-1:0]       = flag_q;
    d_out_d                 = '0;
    if (strobe && !rw && in_range) begin
      d_out_d = addr[0] ? reg1 : reg0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      agr_q     <= '0;
      presc_q   <= '0;
      flag_q    <= '0;
      pending_q <= 1'b0;
      d_out_q   <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      agr_q     <= agr_d;
      presc_q   <= presc_d;
      flag_q    <= flag_d;
      pending_q <= pending_d;
      d_out_q   <= d_out_d;
    end
  end

  assign d_out   = d_out_q;
  assign pending = pending_q;

endmodule
